seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider for the SimpleCalculator datapath, the inverse-operation companion to the combinational array multiplier. It accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock, and presents quotient and remainder with a one-cycle done strobe. The calculator control FSM issues operands and waits for done. The calculator's result mux then selects the quotient/remainder outputs for display.

---
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. Optional macro: DIV_ZERO_FLAG_EN (dz flag, d=0 short-cut).
// Latency: WIDTH+1 cycles from the start cycle to done (1 cycle for d=0 when DIV_ZERO_FLAG_EN is defined).
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done, with no queueing.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             dz
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] wq;
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] pr;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] pr_nxt;
    logic [WIDTH-1:0] wq_nxt;
    logic             last;

    // The partial remainder always stays below the divisor, so only the
    // shifted value and the trial subtraction need the extra sign bit.
    assign pr_sh  = {pr, wq[WIDTH-1]};
    assign trial  = pr_sh - {1'b0, dv};
    assign pr_nxt = trial[WIDTH] ? pr_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign wq_nxt = {wq[WIDTH-2:0], ~trial[WIDTH]};
    assign last   = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FLAG_EN
                    state_nxt = (d == '0) ? S_DONE : S_RUN;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq  <= '0;
            dv  <= '0;
            pr  <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wq  <= n;
                        dv  <= d;
                        pr  <= '0;
                        cnt <= CW'(WIDTH);
`ifdef DIV_ZERO_FLAG_EN
                        dz  <= (d == '0);
                        if (d == '0) begin
                            quo <= '1;
                            rem <= n;
                        end
`endif
                    end
                end
                S_RUN: begin
                    wq  <= wq_nxt;
                    pr  <= pr_nxt;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        quo <= wq_nxt;
                        rem <= pr_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider at WIDTH=4 and WIDTH=8 against an integer div/mod model.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] n4, d4, quo4, rem4;
    logic [7:0] n8, d8, quo8, rem8;
    logic       busy4, done4, busy8, done8;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz4, dz8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .n(n4), .d(d4),
        .quo(quo4), .rem(rem4), .busy(busy4), .done(done4)
`ifdef DIV_ZERO_FLAG_EN
        , .dz(dz4)
`endif
    );

    seq_divider #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8), .d(d8),
        .quo(quo8), .rem(rem8), .busy(busy8), .done(done8)
`ifdef DIV_ZERO_FLAG_EN
        , .dz(dz8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge with the DUT idle.
    task automatic do_div(input int w, input int nn, input int dd, input string tag);
        int          lat, exp_lat, eq, er;
        logic        got, busy_seen, dn, bs, dzv;
        logic [31:0] q, r;
        eq      = (dd == 0) ? (1 << w) - 1 : nn / dd;
        er      = (dd == 0) ? nn : nn % dd;
        exp_lat = w + 1;
`ifdef DIV_ZERO_FLAG_EN
        if (dd == 0) exp_lat = 1;
`endif
        if (w == 4) begin
            start4 = 1'b1; n4 = nn[3:0]; d4 = dd[3:0];
        end else begin
            start8 = 1'b1; n8 = nn[7:0]; d8 = dd[7:0];
        end
        lat = 0; got = 1'b0; busy_seen = 1'b0; bs = 1'b0;
        q = 0; r = 0; dzv = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            start4 = 1'b0; start8 = 1'b0;
            dn  = (w == 4) ? done4 : done8;
            bs  = (w == 4) ? busy4 : busy8;
            q   = (w == 4) ? {28'd0, quo4} : {24'd0, quo8};
            r   = (w == 4) ? {28'd0, rem4} : {24'd0, rem8};
`ifdef DIV_ZERO_FLAG_EN
            dzv = (w == 4) ? dz4 : dz8;
`endif
            busy_seen = busy_seen | bs;
            got = dn;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_quo"}, q, eq);
        check({tag, "_rem"}, r, er);
        check({tag, "_busy_at_done"}, {31'd0, bs}, 0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_dz"}, {31'd0, dzv}, (dd == 0) ? 1 : 0);
        if (dd == 0) check({tag, "_busy_never"}, {31'd0, busy_seen}, 0);
`endif
        @(negedge clk);
        dn = (w == 4) ? done4 : done8;
        check({tag, "_done_1cyc"}, {31'd0, dn}, 0);
`ifdef DIV_ZERO_FLAG_EN
        dzv = (w == 4) ? dz4 : dz8;
        check({tag, "_dz_hold"}, {31'd0, dzv}, (dd == 0) ? 1 : 0);
`endif
    endtask

    initial begin
        int ndone, nn, dd;
        logic [31:0] qv, rv;
        rst = 1'b1;
        start4 = 1'b0; n4 = '0; d4 = '0;
        start8 = 1'b0; n8 = '0; d8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, then idle for ten cycles with start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quo",  {28'd0, quo4}, 0);
            check("idle_rem",  {28'd0, rem4}, 0);
            check("idle_busy", {31'd0, busy4}, 0);
            check("idle_done", {31'd0, done4}, 0);
`ifdef DIV_ZERO_FLAG_EN
            check("idle_dz",   {31'd0, dz4}, 0);
`endif
        end

        do_div(4, 13, 5, "d13_5");
        do_div(4, 15, 1, "d15_1");
        do_div(4, 9, 12, "d9_12");
        do_div(4, 0, 7, "d0_7");

        // A second start and operand changes during RUN must be ignored.
        start4 = 1'b1; n4 = 4'd12; d4 = 4'd5;
        @(negedge clk);
        n4 = 4'd15; d4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        ndone = 0; qv = 0; rv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("ovl_excl", {31'd0, busy4 & done4}, 0);
            if (done4) begin
                ndone++;
                qv = {28'd0, quo4};
                rv = {28'd0, rem4};
            end
        end
        check("ovl_ndone", ndone, 1);
        check("ovl_quo", qv, 2);
        check("ovl_rem", rv, 2);

        // Asynchronous reset on the second RUN cycle discards the operation.
        start4 = 1'b1; n4 = 4'd14; d4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy4}, 0);
        check("abort_quo",  {28'd0, quo4}, 0);
        check("abort_rem",  {28'd0, rem4}, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_div(4, 10, 4, "post_abort");

        do_div(4, 10, 0, "dz10_0");
        do_div(4, 6, 2, "after_dz");

        // Exhaustive WIDTH=4 sweep over nonzero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(4, a, b, $sformatf("ex_%0d_%0d", a, b));
            end
        end

        // Random WIDTH=8 pairs.
        for (int i = 0; i < 200; i++) begin
            nn = int'($urandom_range(0, 255));
            dd = int'($urandom_range(1, 255));
            do_div(8, nn, dd, $sformatf("r8_%0d_%0d", nn, dd));
        end
        do_div(8, 200, 0, "r8_dz");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
